// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU and the two-requester ALU arbiter.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } arb_state_t;

    typedef struct packed {
        logic carry;
        logic zero;
        logic overflow;
        logic negative;
    } alu_flags_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: add, sub (A + ~B + 1), and, or, with carry/zero/overflow/negative.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] BussA,
    input  logic [WIDTH-1:0] BussB,
    input  logic [1:0]       ALUControl,
    output logic [WIDTH-1:0] Output,
    output logic             CarryOut,
    output logic             zero,
    output logic             overflow,
    output logic             negative
);

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;

    always_comb begin
        is_sub   = (ALUControl == ALU_SUB);
        b_eff    = is_sub ? ~BussB : BussB;
        sum      = {1'b0, BussA} + {1'b0, b_eff} + (WIDTH+1)'(is_sub);
        Output   = '0;
        CarryOut = 1'b0;
        overflow = 1'b0;
        case (ALUControl)
            ALU_ADD, ALU_SUB: begin
                Output   = sum[WIDTH-1:0];
                CarryOut = sum[WIDTH];
                // Signed overflow: operands agree in sign, result does not.
                overflow = (BussA[WIDTH-1] == b_eff[WIDTH-1]) &&
                           (sum[WIDTH-1] != BussA[WIDTH-1]);
            end
            ALU_AND: Output = BussA & BussB;
            default: Output = BussA | BussB;
        endcase
        zero     = (Output == '0);
        negative = Output[WIDTH-1];
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; a tie goes to the requester that did not win last.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid_i,
    input  logic       advance_i,
    output logic [1:0] grant_c_o
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        grant_c_o = valid_i;
        if (&valid_i) begin
            grant_c_o = last_grant_q ? 2'b01 : 2'b10;
        end
        last_grant_d = last_grant_q;
        if (advance_i && (|grant_c_o)) begin
            last_grant_d = grant_c_o[1];
        end
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters; results return tagged with the owner id.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_overflow,
    output logic             rsp_negative,
    output logic             busy
);

    arb_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    alu_op_t          op_q, op_d;
    logic             id_q, id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    alu_flags_t       rsp_flags_q, rsp_flags_d;
    logic             busy_q, busy_d;

    logic [1:0]       grant;
    logic             advance;
    logic [WIDTH-1:0] alu_result;
    alu_flags_t       alu_flags;

    rr_arb2 u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_i   ({req1_valid, req0_valid} & {2{state_q == IDLE}}),
        .advance_i (advance),
        .grant_c_o (grant)
    );

    // ALU only ever sees the latched operands.
    alu #(.WIDTH(WIDTH)) u_alu (
        .BussA      (a_q),
        .BussB      (b_q),
        .ALUControl (op_q),
        .Output     (alu_result),
        .CarryOut   (alu_flags.carry),
        .zero       (alu_flags.zero),
        .overflow   (alu_flags.overflow),
        .negative   (alu_flags.negative)
    );

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        advance      = 1'b0;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    advance    = 1'b1;
                    req0_ready = grant[0];
                    req1_ready = grant[1];
                    id_d       = grant[1];
                    a_d        = grant[1] ? req1_a : req0_a;
                    b_d        = grant[1] ? req1_b : req0_b;
                    op_d       = alu_op_t'(grant[1] ? req1_op : req0_op);
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = alu_result;
                rsp_flags_d  = alu_flags;
                rsp_id_d     = id_q;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= ALU_ADD;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            busy_q       <= busy_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_carry    = rsp_flags_q.carry;
    assign rsp_zero     = rsp_flags_q.zero;
    assign rsp_overflow = rsp_flags_q.overflow;
    assign rsp_negative = rsp_flags_q.negative;
    assign busy         = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter: latency, arbitration, backpressure, reset.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]  req0_op, req1_op;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_carry, rsp_zero, rsp_overflow, rsp_negative, busy;
    logic [3:0]  flags;
    logic [1:0]  rdy;

    int vectors     = 0;
    int miscompares = 0;

    assign flags = {rsp_carry, rsp_zero, rsp_overflow, rsp_negative};
    assign rdy   = {req1_ready, req0_ready};

    alu_arbiter #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req0_op      (req0_op),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req1_op      (req1_op),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_carry    (rsp_carry),
        .rsp_zero     (rsp_zero),
        .rsp_overflow (rsp_overflow),
        .rsp_negative (rsp_negative),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    endtask

    task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    endtask

    // Bounded wait, sampled on falling edges, for rsp_valid.
    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (rsp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rsp_ready = 1'b0;
        drive0(1'b0, '0, '0, 2'b00);
        drive1(1'b0, '0, '0, 2'b00);
        @(negedge clk); @(negedge clk);
        vectors++;
        if ({rsp_valid, busy, rsp_id} !== 3'b000) begin
            miscompares++; $display("FAIL reset_ctl got %b want 000", {rsp_valid, busy, rsp_id});
        end
        vectors++;
        if ({rsp_result, flags} !== 36'h0) begin
            miscompares++; $display("FAIL reset_data got %h want 0", {rsp_result, flags});
        end
        vectors++;
        if (rdy !== 2'b00) begin
            miscompares++; $display("FAIL reset_ready got %b want 00", rdy);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add0();
        @(negedge clk);
        drive0(1'b1, 32'h00000DEF, 32'h00000ABC, 2'b00);
        #1;
        vectors++;
        if (rdy !== 2'b01) begin
            miscompares++; $display("FAIL add0_ready got %b want 01", rdy);
        end
        @(negedge clk);
        drive0(1'b0, '0, '0, 2'b00);
        vectors++;
        if ({busy, rsp_valid} !== 2'b10) begin
            miscompares++; $display("FAIL add0_exec busy/valid got %b want 10", {busy, rsp_valid});
        end
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b1) begin
            miscompares++; $display("FAIL add0_latency rsp_valid got %b want 1", rsp_valid);
        end
        vectors++;
        if ({rsp_id, flags} !== 5'b0_0000 || rsp_result !== 32'h000018AB) begin
            miscompares++; $display("FAIL add0_rsp got id/flags %b res %h want 00000 000018ab", {rsp_id, flags}, rsp_result);
        end
        drain();
        vectors++;
        if ({rsp_valid, busy} !== 2'b00 || rsp_result !== 32'h000018AB) begin
            miscompares++; $display("FAIL add0_after got %b %h want 00 000018ab", {rsp_valid, busy}, rsp_result);
        end
    endtask

    task automatic test_ovf1();
        bit ok;
        @(negedge clk);
        drive1(1'b1, 32'h7FFFFFFF, 32'h00000001, 2'b00);
        #1;
        vectors++;
        if (rdy !== 2'b10) begin
            miscompares++; $display("FAIL ovf1_ready got %b want 10", rdy);
        end
        @(negedge clk);
        drive1(1'b0, '0, '0, 2'b00);
        wait_rsp(ok);
        vectors++;
        if (!ok) begin
            miscompares++; $display("FAIL ovf1_timeout got no rsp_valid want rsp_valid=1");
        end
        vectors++;
        if ({rsp_id, flags} !== 5'b1_0011 || rsp_result !== 32'h80000000) begin
            miscompares++; $display("FAIL ovf1_rsp got id/flags %b res %h want 10011 80000000", {rsp_id, flags}, rsp_result);
        end
        drain();
    endtask

    task automatic test_tie_sub();
        bit ok;
        @(negedge clk);
        drive0(1'b1, 32'h80000000, 32'h00000001, 2'b01);
        drive1(1'b1, 32'h00001234, 32'h00000105, 2'b01);
        #1;
        vectors++;
        if (rdy !== 2'b01) begin
            miscompares++; $display("FAIL tie_ready got %b want 01", rdy);
        end
        @(negedge clk);
        drive0(1'b0, '0, '0, 2'b00);
        wait_rsp(ok);
        vectors++;
        if (!ok || {rsp_id, flags} !== 5'b0_1010 || rsp_result !== 32'h7FFFFFFF) begin
            miscompares++; $display("FAIL tie_rsp0 got ok %b id/flags %b res %h want 1 01010 7fffffff", ok, {rsp_id, flags}, rsp_result);
        end
        vectors++;
        if (req1_ready !== 1'b0) begin
            miscompares++; $display("FAIL tie_req1_blocked got %b want 0", req1_ready);
        end
        drain();
        #1;
        vectors++;
        if (rdy !== 2'b10) begin
            miscompares++; $display("FAIL tie_second_ready got %b want 10", rdy);
        end
        @(negedge clk);
        drive1(1'b0, '0, '0, 2'b00);
        wait_rsp(ok);
        vectors++;
        if (!ok || {rsp_id, flags} !== 5'b1_1000 || rsp_result !== 32'h0000112F) begin
            miscompares++; $display("FAIL tie_rsp1 got ok %b id/flags %b res %h want 1 11000 0000112f", ok, {rsp_id, flags}, rsp_result);
        end
        drain();
    endtask

    task automatic test_backpressure();
        bit ok;
        @(negedge clk);
        drive1(1'b1, 32'hF0F0F0F0, 32'h0FF00FF0, 2'b10);
        #1;
        vectors++;
        if (rdy !== 2'b10) begin
            miscompares++; $display("FAIL bp_ready got %b want 10", rdy);
        end
        @(negedge clk);
        wait_rsp(ok);
        vectors++;
        if (!ok || rsp_result !== 32'h00F000F0) begin
            miscompares++; $display("FAIL bp_rsp got ok %b res %h want 1 00f000f0", ok, rsp_result);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({rsp_valid, req1_ready} !== 2'b10 || rsp_result !== 32'h00F000F0 || rsp_id !== 1'b1) begin
                miscompares++; $display("FAIL bp_hold%0d got %b %h id %b want 10 00f000f0 1", i, {rsp_valid, req1_ready}, rsp_result, rsp_id);
            end
        end
        drain();
        #1;
        vectors++;
        if ({rsp_valid, req1_ready} !== 2'b01) begin
            miscompares++; $display("FAIL bp_regrant got %b want 01", {rsp_valid, req1_ready});
        end
        @(negedge clk);
        drive1(1'b0, '0, '0, 2'b00);
        wait_rsp(ok);
        vectors++;
        if (!ok || {rsp_id, flags} !== 5'b1_0000 || rsp_result !== 32'h00F000F0) begin
            miscompares++; $display("FAIL bp_rsp2 got ok %b id/flags %b res %h want 1 10000 00f000f0", ok, {rsp_id, flags}, rsp_result);
        end
        drain();
    endtask

    task automatic test_fairness();
        bit ok;
        logic exp_id;
        @(negedge clk);
        drive0(1'b1, 32'h00000005, 32'h00000005, 2'b01);
        drive1(1'b1, 32'h0000000F, 32'h000000F0, 2'b11);
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_id = (i % 2 == 1);
            wait_rsp(ok);
            vectors++;
            if (!ok || rsp_id !== exp_id) begin
                miscompares++; $display("FAIL fair_id%0d got ok %b id %b want 1 %b", i, ok, rsp_id, exp_id);
            end
            vectors++;
            if (!exp_id && {rsp_result, flags} !== {32'h00000000, 4'b1100}) begin
                miscompares++; $display("FAIL fair_zero%0d got %h %b want 00000000 1100", i, rsp_result, flags);
            end else if (exp_id && {rsp_result, flags} !== {32'h000000FF, 4'b0000}) begin
                miscompares++; $display("FAIL fair_or%0d got %h %b want 000000ff 0000", i, rsp_result, flags);
            end
            @(negedge clk);
        end
        drive0(1'b0, '0, '0, 2'b00);
        drive1(1'b0, '0, '0, 2'b00);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_exec();
        bit ok;
        @(negedge clk);
        drive0(1'b1, 32'h00000001, 32'h00000002, 2'b00);
        @(negedge clk);
        drive0(1'b0, '0, '0, 2'b00);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++; $display("FAIL rst_exec_busy got %b want 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({rsp_valid, busy} !== 2'b00) begin
            miscompares++; $display("FAIL rst_exec_drop got %b want 00", {rsp_valid, busy});
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if ({rsp_valid, busy} !== 2'b00) begin
                miscompares++; $display("FAIL rst_no_rsp%0d got %b want 00", i, {rsp_valid, busy});
            end
        end
        vectors++;
        if ({rsp_id, rsp_result} !== 33'h0) begin
            miscompares++; $display("FAIL rst_rsp_cleared got %h want 0", {rsp_id, rsp_result});
        end
        drive0(1'b1, 32'h0000000A, 32'h0000000B, 2'b00);
        drive1(1'b1, 32'h00000003, 32'h00000004, 2'b00);
        #1;
        vectors++;
        if (rdy !== 2'b01) begin
            miscompares++; $display("FAIL rst_tie_ready got %b want 01", rdy);
        end
        @(negedge clk);
        drive0(1'b0, '0, '0, 2'b00);
        drive1(1'b0, '0, '0, 2'b00);
        wait_rsp(ok);
        vectors++;
        if (!ok || rsp_id !== 1'b0 || rsp_result !== 32'h00000015) begin
            miscompares++; $display("FAIL rst_tie_rsp got ok %b id %b res %h want 1 0 00000015", ok, rsp_id, rsp_result);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_add0();
        test_ovf1();
        test_tie_sub();
        test_backpressure();
        test_fairness();
        test_reset_exec();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
